sdram_frame_scheduler: RTL



---
 rtl/sdram_frame_scheduler.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sdram_frame_scheduler.sv
// SDRAM burst scheduler for the camera-write / VGA-read frame-buffer path.
// Arbitrates one outstanding burst at a time between the write FIFO drain
// and the read FIFO fill, and rotates three frame buffers so the display
// only ever shows completely written camera frames.
module sdram_frame_scheduler #(
   parameter int unsigned BURST_LEN   = 256,
   parameter int unsigned FRAME_WORDS = 307200,
   parameter int unsigned BUF_STRIDE  = 524288,
   parameter int unsigned ADDR_W      = 23,
   parameter int unsigned LVL_W       = 10,
   parameter int unsigned RD_LOW      = 256,
   parameter int unsigned FIFO_DEPTH  = 512
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic [LVL_W-1:0]  wr_level,
   input  logic [LVL_W-1:0]  rd_level,
   input  logic              wr_frame_start,
   input  logic              rd_frame_start,
   output logic              cmd_valid,
   output logic              cmd_write,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [8:0]        cmd_len,
   input  logic              cmd_ready,
   input  logic              cmd_done,
   output logic [1:0]        wr_buf,
   output logic [1:0]        rd_buf,
   output logic [7:0]        drop_cnt,
   output logic              wr_overflow
);

   localparam int unsigned CNT_W = $clog2(FRAME_WORDS + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] wr_cnt, rd_cnt;
   logic [1:0]       ready_buf;
   logic             ready_valid;
   logic             pend_rd, pend_wr;
   logic             last_wr;

   // Post-event view of the frame state, valid in IDLE before arbitration
   logic             apply_rd, apply_wr, drop_inc;
   logic [1:0]       e_rd_buf, e_wr_buf, idx;
   logic [CNT_W-1:0] e_rd_cnt, e_wr_cnt;
   logic             e_ready_valid;
   logic [CNT_W-1:0] wr_rem, rd_rem, wr_len, rd_len;
   logic             wr_req, rd_req, grant, gnt_wr;

   // Apply pending frame events (read first, then write) and arbitrate
   always_comb begin
      apply_rd      = (state == IDLE) && (pend_rd || rd_frame_start);
      apply_wr      = (state == IDLE) && (pend_wr || wr_frame_start);
      e_rd_buf      = rd_buf;
      e_rd_cnt      = rd_cnt;
      e_ready_valid = ready_valid;
      e_wr_buf      = wr_buf;
      e_wr_cnt      = wr_cnt;
      drop_inc      = 1'b0;
      idx           = 2'd0;
      if (apply_rd) begin
         if (ready_valid) begin
            e_rd_buf      = ready_buf;
            e_ready_valid = 1'b0;
         end
         e_rd_cnt = '0;
      end
      if (apply_wr) begin
         drop_inc = (wr_cnt != '0) && (wr_cnt != CNT_W'(FRAME_WORDS));
         // Scan high to low so the lowest qualifying index wins
         for (int unsigned i = 0; i < 3; i++) begin
            idx = 2'(2 - i);
            if (idx != e_rd_buf && !(e_ready_valid && idx == ready_buf))
               e_wr_buf = idx;
         end
         e_wr_cnt = '0;
      end
      wr_rem = CNT_W'(FRAME_WORDS) - e_wr_cnt;
      rd_rem = CNT_W'(FRAME_WORDS) - e_rd_cnt;
      wr_len = (wr_rem > CNT_W'(BURST_LEN)) ? CNT_W'(BURST_LEN) : wr_rem;
      rd_len = (rd_rem > CNT_W'(BURST_LEN)) ? CNT_W'(BURST_LEN) : rd_rem;
      wr_req = (e_wr_cnt < CNT_W'(FRAME_WORDS)) && (CNT_W'(wr_level) >= wr_len);
      rd_req = (e_rd_cnt < CNT_W'(FRAME_WORDS)) && (rd_level < LVL_W'(RD_LOW));
      grant  = (state == IDLE) && (wr_req || rd_req);
      gnt_wr = wr_req && (!rd_req || !last_wr);
   end

   // State register
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state <= IDLE;
      else          state <= state_nx;
   end

   // Next-state logic: grant -> present command -> wait for burst completion
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (grant)     state_nx = ISSUE;
         ISSUE:   if (cmd_ready) state_nx = BUSY;
         BUSY:    if (cmd_done)  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output logic: command is offered only while in ISSUE
   always_comb begin
      cmd_valid = (state == ISSUE);
   end

   // Frame bookkeeping, counters and registered command fields
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cmd_write   <= 1'b0;
         cmd_addr    <= '0;
         cmd_len     <= '0;
         wr_buf      <= 2'd0;
         rd_buf      <= 2'd1;
         ready_buf   <= 2'd2;
         ready_valid <= 1'b0;
         wr_cnt      <= '0;
         rd_cnt      <= '0;
         drop_cnt    <= '0;
         wr_overflow <= 1'b0;
         pend_rd     <= 1'b0;
         pend_wr     <= 1'b0;
         last_wr     <= 1'b1;
      end else begin
         pend_rd <= apply_rd ? 1'b0 : (pend_rd | rd_frame_start);
         pend_wr <= apply_wr ? 1'b0 : (pend_wr | wr_frame_start);
         if (wr_level == LVL_W'(FIFO_DEPTH)) wr_overflow <= 1'b1;
         if (state == IDLE) begin
            rd_buf      <= e_rd_buf;
            rd_cnt      <= e_rd_cnt;
            ready_valid <= e_ready_valid;
            wr_buf      <= e_wr_buf;
            wr_cnt      <= e_wr_cnt;
            if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            if (grant) begin
               last_wr   <= gnt_wr;
               cmd_write <= gnt_wr;
               if (gnt_wr) begin
                  cmd_addr <= ADDR_W'(e_wr_buf) * ADDR_W'(BUF_STRIDE) + ADDR_W'(e_wr_cnt);
                  cmd_len  <= 9'(wr_len);
               end else begin
                  cmd_addr <= ADDR_W'(e_rd_buf) * ADDR_W'(BUF_STRIDE) + ADDR_W'(e_rd_cnt);
                  cmd_len  <= 9'(rd_len);
               end
            end
         end else if (state == BUSY && cmd_done) begin
            if (cmd_write) begin
               wr_cnt <= wr_cnt + CNT_W'(cmd_len);
               if (wr_cnt + CNT_W'(cmd_len) == CNT_W'(FRAME_WORDS)) begin
                  ready_buf   <= wr_buf;
                  ready_valid <= 1'b1;
               end
            end else begin
               rd_cnt <= rd_cnt + CNT_W'(cmd_len);
            end
         end
      end
   end

endmodule
